// File: rtl/wave_sched.sv
// Four-segment programmable waveform scheduler: plays a {level, duration} table
// for a fixed number of passes (or continuously) and drives a registered waveform.
module wave_sched #(
    parameter int   DUR_W      = 8,
    parameter int   PASS_W     = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              stop,
    input  logic [PASS_W-1:0] passes,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic              cfg_level,
    input  logic [DUR_W-1:0]  cfg_dur,
    output logic              wave_out,
    output logic              busy,
    output logic              done,
    output logic [1:0]        seg_idx,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             level_q;
    logic [3:0][DUR_W-1:0]  dur_q;
    logic [1:0]             seg_q, seg_d;
    logic [DUR_W-1:0]       cnt_q, cnt_d;
    logic [PASS_W-1:0]      pass_q, pass_d;
    logic [PASS_W-1:0]      passes_q, passes_d;
    logic                   wave_q, wave_d;
    logic                   done_q, done_d;

    logic [3:0]             nz;
    logic [1:0]             first_idx, next_idx;
    logic                   next_ok;
    logic [PASS_W-1:0]      pass_inc;

    for (genvar gi = 0; gi < 4; gi++) begin : g_nz
        assign nz[gi] = (dur_q[gi] != '0);
    end

    // Zero-duration segments are skipped here, so advancing never costs a cycle.
    always_comb begin
        first_idx = 2'd0;
        next_idx  = 2'd0;
        next_ok   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (nz[i]) first_idx = 2'(i);
            if (nz[i] && (2'(i) > seg_q)) begin
                next_idx = 2'(i);
                next_ok  = 1'b1;
            end
        end
    end

    assign pass_inc = pass_q + PASS_W'(1);

    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        passes_d = passes_q;
        wave_d   = wave_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    pass_d = '0;
                    if (|nz) begin
                        state_d  = RUN;
                        passes_d = passes;
                        seg_d    = first_idx;
                        cnt_d    = dur_q[first_idx] - DUR_W'(1);
                        wave_d   = level_q[first_idx];
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    seg_d   = 2'd0;
                    wave_d  = IDLE_LEVEL;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DUR_W'(1);
                end else if (next_ok) begin
                    seg_d  = next_idx;
                    cnt_d  = dur_q[next_idx] - DUR_W'(1);
                    wave_d = level_q[next_idx];
                end else begin
                    pass_d = pass_inc;
                    if ((passes_q != '0) && (pass_inc == passes_q)) begin
                        state_d = IDLE;
                        seg_d   = 2'd0;
                        wave_d  = IDLE_LEVEL;
                        done_d  = 1'b1;
                    end else begin
                        seg_d  = first_idx;
                        cnt_d  = dur_q[first_idx] - DUR_W'(1);
                        wave_d = level_q[first_idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            seg_q    <= 2'd0;
            cnt_q    <= '0;
            pass_q   <= '0;
            passes_q <= '0;
            wave_q   <= IDLE_LEVEL;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            passes_q <= passes_d;
            wave_q   <= wave_d;
            done_q   <= done_d;
        end
    end

    // Table is writable only while idle so a run always sees a stable schedule.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_q  <= 4'b1010;
            dur_q[0] <= DUR_W'(12);
            dur_q[1] <= DUR_W'(5);
            dur_q[2] <= DUR_W'(3);
            dur_q[3] <= DUR_W'(10);
        end else if (cfg_we && (state_q == IDLE)) begin
            level_q[cfg_addr] <= cfg_level;
            dur_q[cfg_addr]   <= cfg_dur;
        end
    end

    assign wave_out = wave_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign seg_idx  = seg_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_wave_sched.sv
// Directed bench for wave_sched: per-scenario tasks with hand-derived expected waveforms.
module tb_wave_sched;

    localparam int DUR_W  = 8;
    localparam int PASS_W = 8;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [PASS_W-1:0] passes = '0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_addr = '0;
    logic              cfg_level = 1'b0;
    logic [DUR_W-1:0]  cfg_dur = '0;
    logic              wave_out, busy, done;
    logic [1:0]        seg_idx;
    logic [PASS_W-1:0] pass_cnt;

    int nvec = 0;
    int nerr = 0;

    wave_sched #(.DUR_W(DUR_W), .PASS_W(PASS_W), .IDLE_LEVEL(1'b0)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .passes(passes),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_level(cfg_level), .cfg_dur(cfg_dur),
        .wave_out(wave_out), .busy(busy), .done(done), .seg_idx(seg_idx), .pass_cnt(pass_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        cycle(); cycle();
        RST_N = 1'b1;
        cycle();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic l, input logic [DUR_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_level = l; cfg_dur = d;
        cycle();
        cfg_we = 1'b0;
    endtask

    // Returns with outputs reflecting edge E0 (k = 0).
    task automatic do_start(input logic [PASS_W-1:0] p);
        start = 1'b1; passes = p;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        nvec++;
        if (wave_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || seg_idx !== 2'd0 || pass_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL reset_values wave=%b busy=%b done=%b seg=%0d pass=%0d, required 0 0 0 0 0",
                     wave_out, busy, done, seg_idx, pass_cnt);
        end
        do_reset();
        nvec++;
        if (wave_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || seg_idx !== 2'd0) begin
            nerr++;
            $display("FAIL reset_release wave=%b busy=%b done=%b seg=%0d, required 0 0 0 0",
                     wave_out, busy, done, seg_idx);
        end
        $display("reset: checked");
    endtask

    task automatic test_single_pass();
        logic ew, eb, ed;
        logic [1:0] es;
        do_reset();
        do_start(8'd1);
        for (int k = 0; k <= 31; k++) begin
            if (k > 0) cycle();
            ew = (k < 12) ? 1'b0 : (k < 17) ? 1'b1 : (k < 20) ? 1'b0 : (k < 30) ? 1'b1 : 1'b0;
            es = (k < 12) ? 2'd0 : (k < 17) ? 2'd1 : (k < 20) ? 2'd2 : (k < 30) ? 2'd3 : 2'd0;
            eb = (k < 30);
            ed = (k == 30);
            nvec++;
            if (wave_out !== ew || seg_idx !== es || busy !== eb || done !== ed) begin
                nerr++;
                $display("FAIL single_pass k=%0d wave=%b/%b seg=%0d/%0d busy=%b/%b done=%b/%b (got/required)",
                         k, wave_out, ew, seg_idx, es, busy, eb, done, ed);
            end
        end
        nvec++;
        if (pass_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL single_pass_cnt got %0d required 1", pass_cnt);
        end
        $display("single_pass: 32 cycles checked");
    endtask

    task automatic test_multi_pass();
        logic ew, eb, ed;
        logic [1:0] es;
        int p;
        do_reset();
        cfg_write(2'd1, 1'b1, 8'd0);
        do_start(8'd3);
        for (int k = 0; k <= 76; k++) begin
            if (k > 0) cycle();
            p  = k % 25;
            ew = (k >= 75) ? 1'b0 : (p < 15) ? 1'b0 : 1'b1;
            es = (k >= 75) ? 2'd0 : (p < 12) ? 2'd0 : (p < 15) ? 2'd2 : 2'd3;
            eb = (k < 75);
            ed = (k == 75);
            nvec++;
            if (wave_out !== ew || seg_idx !== es || busy !== eb || done !== ed) begin
                nerr++;
                $display("FAIL multi_pass k=%0d wave=%b/%b seg=%0d/%0d busy=%b/%b done=%b/%b (got/required)",
                         k, wave_out, ew, seg_idx, es, busy, eb, done, ed);
            end
            if (k == 24 || k == 25 || k == 50 || k == 76) begin
                nvec++;
                if (pass_cnt !== ((k == 24) ? 8'd0 : (k == 25) ? 8'd1 : (k == 50) ? 8'd2 : 8'd3)) begin
                    nerr++;
                    $display("FAIL multi_pass_cnt k=%0d got %0d", k, pass_cnt);
                end
            end
        end
        $display("multi_pass: 3 x 25 cycles checked");
    endtask

    task automatic test_continuous_stop();
        do_reset();
        do_start(8'd0);
        for (int k = 1; k <= 39; k++) begin
            cycle();
            if (k == 30) begin
                nvec++;
                if (busy !== 1'b1 || done !== 1'b0 || pass_cnt !== 8'd1 || seg_idx !== 2'd0) begin
                    nerr++;
                    $display("FAIL cont_wrap busy=%b done=%b pass=%0d seg=%0d, required 1 0 1 0",
                             busy, done, pass_cnt, seg_idx);
                end
            end
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        nvec++;
        if (busy !== 1'b0 || wave_out !== 1'b0 || done !== 1'b0 || pass_cnt !== 8'd1 || seg_idx !== 2'd0) begin
            nerr++;
            $display("FAIL cont_stop busy=%b wave=%b done=%b pass=%0d seg=%0d, required 0 0 0 1 0",
                     busy, wave_out, done, pass_cnt, seg_idx);
        end
        for (int k = 41; k <= 43; k++) begin
            cycle();
            nvec++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                nerr++;
                $display("FAIL cont_after_stop k=%0d busy=%b done=%b, required 0 0", k, busy, done);
            end
        end
        $display("continuous_stop: stop at E0+40 checked");
    endtask

    task automatic test_config_lock();
        do_reset();
        do_start(8'd1);
        for (int k = 1; k <= 4; k++) cycle();
        cfg_write(2'd0, 1'b0, 8'd2);
        for (int k = 6; k <= 29; k++) cycle();
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL lock_busy_k29 busy=%b done=%b, required 1 0", busy, done);
        end
        cycle();
        nvec++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            nerr++;
            $display("FAIL lock_done_k30 busy=%b done=%b, required 0 1", busy, done);
        end
        cfg_write(2'd0, 1'b0, 8'd2);
        do_start(8'd1);
        cycle(); cycle();
        nvec++;
        if (wave_out !== 1'b1 || seg_idx !== 2'd1) begin
            nerr++;
            $display("FAIL idle_write_k2 wave=%b seg=%0d, required 1 1", wave_out, seg_idx);
        end
        for (int k = 3; k <= 19; k++) cycle();
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL idle_write_k19 busy=%b done=%b, required 1 0", busy, done);
        end
        cycle();
        nvec++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            nerr++;
            $display("FAIL idle_write_k20 busy=%b done=%b, required 0 1", busy, done);
        end
        $display("config_lock: 30-cycle locked pass, 20-cycle pass after idle write");
    endtask

    task automatic test_simultaneous();
        do_reset();
        start = 1'b1; stop = 1'b1; passes = 8'd1;
        cycle();
        start = 1'b0; stop = 1'b0;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || wave_out !== 1'b0) begin
            nerr++;
            $display("FAIL start_stop_same busy=%b done=%b wave=%b, required 0 0 0", busy, done, wave_out);
        end
        cycle();
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL start_stop_next busy=%b done=%b, required 0 0", busy, done);
        end
        $display("simultaneous: start+stop produced no run");
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_start(8'd1);
        for (int k = 1; k <= 10; k++) cycle();
        start = 1'b1; passes = 8'd5;
        cycle();
        start = 1'b0;
        cycle();
        nvec++;
        if (wave_out !== 1'b1 || seg_idx !== 2'd1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL restart_k12 wave=%b seg=%0d busy=%b, required 1 1 1", wave_out, seg_idx, busy);
        end
        for (int k = 13; k <= 29; k++) cycle();
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL restart_k29 busy=%b done=%b, required 1 0", busy, done);
        end
        cycle();
        nvec++;
        if (busy !== 1'b0 || done !== 1'b1 || pass_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL restart_k30 busy=%b done=%b pass=%0d, required 0 1 1", busy, done, pass_cnt);
        end
        $display("back_to_back: start during run ignored");
    endtask

    task automatic test_degenerate();
        do_reset();
        for (int a = 0; a < 4; a++) cfg_write(2'(a), 1'b1, 8'd0);
        do_start(8'd1);
        nvec++;
        if (busy !== 1'b0 || done !== 1'b1 || wave_out !== 1'b0) begin
            nerr++;
            $display("FAIL degen_e0 busy=%b done=%b wave=%b, required 0 1 0", busy, done, wave_out);
        end
        cycle();
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL degen_e1 busy=%b done=%b, required 0 0", busy, done);
        end
        $display("degenerate: single done pulse, no run");
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_write(2'd0, 1'b0, 8'd2);
        do_start(8'd1);
        for (int k = 1; k <= 4; k++) cycle();
        nvec++;
        if (wave_out !== 1'b1 || seg_idx !== 2'd1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL async_pre wave=%b seg=%0d busy=%b, required 1 1 1", wave_out, seg_idx, busy);
        end
        #3;
        RST_N = 1'b0;
        #1;
        nvec++;
        if (wave_out !== 1'b0 || busy !== 1'b0 || seg_idx !== 2'd0 || done !== 1'b0 || pass_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL async_assert wave=%b busy=%b seg=%0d done=%b pass=%0d, required 0 0 0 0 0",
                     wave_out, busy, seg_idx, done, pass_cnt);
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cycle();
        do_start(8'd1);
        for (int k = 1; k <= 20; k++) cycle();
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL async_table_k20 busy=%b done=%b, required 1 0", busy, done);
        end
        for (int k = 21; k <= 30; k++) cycle();
        nvec++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            nerr++;
            $display("FAIL async_table_k30 busy=%b done=%b, required 0 1", busy, done);
        end
        $display("async_reset: outputs and table restored");
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_continuous_stop();
        test_config_lock();
        test_simultaneous();
        test_back_to_back();
        test_degenerate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wave_sched.md
# wave_sched

Programmable four-segment asymmetric waveform scheduler. It generates a clock-like output `wave_out` from a table of (level, duration) segments, for a requested number of passes or continuously. It is the synthesizable controller that replaces behavioural `#delay` clock-sequencing tasks in the chap8 benches. Bench logic and downstream blocks use `wave_out` as a gated strobe or derived clock-enable.

## Interface
Parameters:
- `DUR_W`, 8: width of each segment duration, in CLK cycles.
- `PASS_W`, 8: width of the pass count and the pass counter.
- `IDLE_LEVEL`, 1'b0: value of `wave_out` when not running.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  start request pulse.
- `stop`  in  1  abort request.
- `passes`  in  PASS_W  number of passes to run, sampled with `start`; 0 means continuous.
- `cfg_we`  in  1  segment table write enable.
- `cfg_addr`  in  2  segment index 0..3.
- `cfg_level`  in  1  output level for the segment.
- `cfg_dur`  in  DUR_W  segment length in cycles; 0 means skip the segment.
- `wave_out`  out  1  generated waveform, registered.
- `busy`  out  1  high while the scheduler is running.
- `done`  out  1  one-cycle pulse on normal completion.
- `seg_idx`  out  2  index of the active segment; 0 when idle.
- `pass_cnt`  out  PASS_W  number of completed passes in the current run.

## Operation
- **Segment table.** Four entries of {level, dur}.
- **Reset contents of the table:** {0,12}, {1,5}, {0,3}, {1,10}.
- **Reset values of outputs:** `wave_out`=IDLE_LEVEL, `busy`=0, `done`=0, `seg_idx`=0, `pass_cnt`=0, FSM in IDLE.
- **Table writes.** Accepted only while `busy`=0. Writes while busy are ignored, and the table is stable during a run.
- **IDLE state.**
  - If `start`=1 and `stop`=0, latch `passes` and go to RUN.
  - RUN loads the first segment with dur≠0 and clears `pass_cnt`.
  - If all four durations are 0, stay in IDLE and pulse `done` the next cycle, with `busy` remaining 0.
- **RUN state.**
  - `wave_out` = level of the active segment.
  - A down-counter is loaded with dur and decrements each cycle.
  - When the count expires, advance to the next nonzero segment.
  - Skipping of zero-duration segments is combinational, with no idle cycle.
- **End of pass.** Leaving the last nonzero segment increments `pass_cnt`. `pass_cnt` wraps modulo 2^PASS_W in continuous mode.
  - If `pass_cnt`+1 equals the latched passes (nonzero), go to IDLE: `busy`=0, `done`=1 for one cycle, `wave_out`=IDLE_LEVEL, `seg_idx`=0. `pass_cnt` holds its final value until the next start.
  - Otherwise wrap to the first nonzero segment seamlessly, with no gap cycle.
- **stop.**
  - In RUN, go to IDLE on the next edge with `wave_out`=IDLE_LEVEL and no `done` pulse.
  - In IDLE, `stop` suppresses `start` in the same cycle.
- **start during RUN** is ignored.
- **Reset mid-run** immediately restores all reset values, including the segment table.

## Timing
- **Start.** `start` is sampled at edge E0. From E0, `busy`=1 and `wave_out` = first segment level.
- **Segment length.** A segment of duration d holds `wave_out` for exactly d cycles.
- **Pass length.** One pass lasts the sum of the nonzero durations.
- **Completion.** For N passes of total length L, `busy` falls and `done` rises at edge E0+N·L. `done` deasserts one cycle later.
- **Output timing.** `seg_idx` changes on the same edge as `wave_out`. All outputs are registered, with no combinational input-to-output path.
- **Stop.** `stop` sampled at edge Es gives `busy`=0 and `wave_out`=IDLE_LEVEL from Es.

## Test plan
- **Reset defaults, single pass.** Release reset, then `start` with `passes`=1 at E0 → `wave_out`:
  - 0 over E0–E12,
  - 1 over E12–E17,
  - 0 over E17–E20,
  - 1 over E20–E30;
  - then `busy`=0 and `done`=1 at E30 only, `pass_cnt`=1.
- **Multi-pass and zero-duration skip.** Write seg1 dur=0, then `passes`=3 → pattern 12 low, 3 low, 10 high (25 cycles) repeated 3 times with no gaps; `done` at E0+75; `seg_idx` never shows 1.
- **Continuous mode with mid-run stop.** `passes`=0, `stop` at E0+40 → `busy`=0 and `wave_out`=0 from E0+40, no `done`, `pass_cnt`=1.
- **Configuration lock.** `cfg_we` to seg0 with dur=2 while busy → ignored, and the pass remains 30 cycles. The same write while idle → the next pass is 20 cycles.
- **Simultaneous and redundant requests.**
  - `start` and `stop` in the same idle cycle → no run.
  - `start` during RUN → no restart, and `done` timing is unchanged.
- **Degenerate table and async reset.**
  - All durations 0, then `start` → `busy` stays 0 and `done` pulses once.
  - `RST_N` asserted asynchronously mid-segment → outputs return to reset values immediately and the table returns to its defaults.
